// File: rtl/serial_mul_accumulator.sv
// Sums `terms` unsigned products, rounds half-up at frac_bits and returns a width-bit result.
// Define ACC_SATURATE_EN to clamp overflowing results to all ones instead of wrapping.
module serial_mul_accumulator #(
  parameter int width     = 64,
  parameter int frac_bits = 32,
  parameter int terms     = 8
) (
  input  logic               clk,
  input  logic               asyn_reset,
  input  logic [2*width-1:0] product,
  input  logic               d_in_vld,
  output logic               d_in_rdy,
  output logic [width-1:0]   acc_out,
  output logic               overflow,
  output logic               acc_out_vld,
  input  logic               acc_out_rdy
);

  localparam int AW = 2*width + 8;
  // Shifting the one back down yields zero when no fraction bits are dropped.
  localparam logic [AW:0]  HALF = ((AW+1)'(1) << frac_bits) >> 1;
  localparam logic [7:0]   LAST = 8'(terms - 1);

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_ROUND = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_acc;
  logic [7:0]        r_cnt;
  logic [width-1:0]  r_acc_out;
  logic              r_overflow;
  logic              r_acc_out_vld;
  logic [AW:0]       w_rounded;
  logic              w_ovf;
  logic              w_last;

  assign w_rounded = ({1'b0, r_acc} + HALF) >> frac_bits;
  assign w_ovf     = |w_rounded[AW:width];
  assign w_last    = (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) r_state <= ST_ACC;
    else             r_state <= w_state_nxt;
  end

  // NOTE: defaults come first so no path through the case leaves an output unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    d_in_rdy    = 1'b0;
    unique case (r_state)
      ST_ACC: begin
        d_in_rdy = 1'b1;
        if (d_in_vld && w_last) w_state_nxt = ST_ROUND;
      end
      ST_ROUND: w_state_nxt = ST_OUT;
      ST_OUT:   if (acc_out_rdy) w_state_nxt = ST_ACC;
      default:  w_state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      r_acc         <= '0;
      r_cnt         <= '0;
      r_acc_out     <= '0;
      r_overflow    <= 1'b0;
      r_acc_out_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (d_in_vld) begin
            r_acc <= r_acc + AW'(product);
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_ROUND: begin
          r_overflow    <= w_ovf;
          r_acc_out_vld <= 1'b1;
          if (w_ovf) begin
`ifdef ACC_SATURATE_EN
            r_acc_out <= '1;
`else
            r_acc_out <= w_rounded[width-1:0];
`endif
          end else begin
            r_acc_out <= w_rounded[width-1:0];
          end
        end
        ST_OUT: begin
          if (acc_out_rdy) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_acc_out_vld <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: restart cleanly on the way back to ACC.
          r_acc         <= '0;
          r_cnt         <= '0;
          r_acc_out_vld <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out     = r_acc_out;
  assign overflow    = r_overflow;
  assign acc_out_vld = r_acc_out_vld;

endmodule

// File: tb/tb_serial_mul_accumulator.sv
// Directed bench for serial_mul_accumulator at width=8, frac_bits=4, terms=4.
module tb_serial_mul_accumulator;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           asyn_reset;
  logic [2*W-1:0] product;
  logic           d_in_vld;
  logic           d_in_rdy;
  logic [W-1:0]   acc_out;
  logic           overflow;
  logic           acc_out_vld;
  logic           acc_out_rdy;

  int n_checks = 0;
  int n_bad    = 0;

  serial_mul_accumulator #(.width(W), .frac_bits(4), .terms(4)) dut (
    .clk         (clk),
    .asyn_reset  (asyn_reset),
    .product     (product),
    .d_in_vld    (d_in_vld),
    .d_in_rdy    (d_in_rdy),
    .acc_out     (acc_out),
    .overflow    (overflow),
    .acc_out_vld (acc_out_vld),
    .acc_out_rdy (acc_out_rdy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2*W-1:0] p);
    int budget = 50;
    product  = p;
    d_in_vld = 1'b1;
    while (!d_in_rdy) begin
      if (budget == 0) begin
        $display("FAIL send_timeout: d_in_rdy=%b required=1", d_in_rdy);
        $fatal(1, "input handshake never completed");
      end
      budget--;
      step();
    end
    step();
    d_in_vld = 1'b0;
  endtask

  task automatic wait_out();
    int budget = 50;
    while (!acc_out_vld) begin
      if (budget == 0) begin
        $display("FAIL out_timeout: acc_out_vld=%b required=1", acc_out_vld);
        $fatal(1, "result never became valid");
      end
      budget--;
      step();
    end
  endtask

  task automatic take_out();
    acc_out_rdy = 1'b1;
    step();
    acc_out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b0; product = '0; d_in_vld = 1'b0; acc_out_rdy = 1'b0;
    #3;
    n_checks++; if (acc_out_vld !== 1'b0) begin n_bad++; $display("FAIL rst_vld: got=%b exp=0", acc_out_vld); end
    n_checks++; if (acc_out !== 8'h00) begin n_bad++; $display("FAIL rst_out: got=%h exp=00", acc_out); end
    n_checks++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got=%b exp=0", overflow); end
    step();
    asyn_reset = 1'b1;
    #1;
    n_checks++; if (d_in_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_rdy: got=%b exp=1", d_in_rdy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send(16'h0100);
    n_checks++; if (acc_out_vld !== 1'b0) begin n_bad++; $display("FAIL b2b_round_vld: got=%b exp=0", acc_out_vld); end
    n_checks++; if (d_in_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_round_rdy: got=%b exp=0", d_in_rdy); end
    step();
    n_checks++; if (acc_out_vld !== 1'b1) begin n_bad++; $display("FAIL b2b_vld_latency: got=%b exp=1", acc_out_vld); end
    n_checks++; if (acc_out !== 8'h40) begin n_bad++; $display("FAIL b2b_out: got=%h exp=40", acc_out); end
    n_checks++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf: got=%b exp=0", overflow); end
    take_out();
    n_checks++; if (acc_out_vld !== 1'b0) begin n_bad++; $display("FAIL b2b_vld_drop: got=%b exp=0", acc_out_vld); end
    n_checks++; if (d_in_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy_back: got=%b exp=1", d_in_rdy); end
  endtask

  task automatic test_round();
    send(16'h0008); for (int i = 0; i < 3; i++) send(16'h0000);
    wait_out();
    n_checks++; if (acc_out !== 8'h01) begin n_bad++; $display("FAIL round_up: got=%h exp=01", acc_out); end
    take_out();
    send(16'h0007); for (int i = 0; i < 3; i++) send(16'h0000);
    wait_out();
    n_checks++; if (acc_out !== 8'h00) begin n_bad++; $display("FAIL round_down: got=%h exp=00", acc_out); end
    take_out();
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_out;
`ifdef ACC_SATURATE_EN
    exp_out = 8'hFF;
`else
    exp_out = 8'h00;
`endif
    for (int i = 0; i < 4; i++) send(16'hFFFF);
    wait_out();
    n_checks++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got=%b exp=1", overflow); end
    n_checks++; if (acc_out !== exp_out) begin n_bad++; $display("FAIL ovf_out: got=%h exp=%h", acc_out, exp_out); end
    take_out();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) send(16'h0100);
    wait_out();
    n_checks++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_ovf_clear: got=%b exp=0", overflow); end
    for (int i = 0; i < 5; i++) begin
      d_in_vld = (i % 2 == 0);
      product  = 16'h1234;
      step();
      n_checks++; if (acc_out_vld !== 1'b1) begin n_bad++; $display("FAIL bp_vld_hold[%0d]: got=%b exp=1", i, acc_out_vld); end
      n_checks++; if (acc_out !== 8'h40) begin n_bad++; $display("FAIL bp_out_hold[%0d]: got=%h exp=40", i, acc_out); end
      n_checks++; if (d_in_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_rdy_low[%0d]: got=%b exp=0", i, d_in_rdy); end
    end
    d_in_vld = 1'b0;
    take_out();
    for (int i = 0; i < 4; i++) send(16'h0010);
    wait_out();
    n_checks++; if (acc_out !== 8'h04) begin n_bad++; $display("FAIL bp_next_batch: got=%h exp=04", acc_out); end
    take_out();
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 4; i++) begin
      send(16'h0020);
      step();
      if (i == 2) begin
        n_checks++; if (d_in_rdy !== 1'b1) begin n_bad++; $display("FAIL gap_rdy_after3: got=%b exp=1", d_in_rdy); end
      end
    end
    wait_out();
    n_checks++; if (acc_out !== 8'h08) begin n_bad++; $display("FAIL gap_out: got=%h exp=08", acc_out); end
    take_out();
  endtask

  task automatic test_reset_mid();
    send(16'h0100); send(16'h0100);
    asyn_reset = 1'b0;
    #1;
    n_checks++; if (acc_out_vld !== 1'b0) begin n_bad++; $display("FAIL midrst_vld: got=%b exp=0", acc_out_vld); end
    n_checks++; if (acc_out !== 8'h00) begin n_bad++; $display("FAIL midrst_out: got=%h exp=00", acc_out); end
    step();
    asyn_reset = 1'b1;
    #1;
    n_checks++; if (d_in_rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_rdy: got=%b exp=1", d_in_rdy); end
    for (int i = 0; i < 4; i++) send(16'h0010);
    wait_out();
    n_checks++; if (acc_out !== 8'h04) begin n_bad++; $display("FAIL midrst_batch: got=%h exp=04", acc_out); end
    take_out();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_round();
    test_overflow();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
